// File: rtl/concat_scheduler_pkg.sv
// Shared constants and types for the concat layer scheduler.
// State encoding, register-bus width and error bit positions.
package concat_scheduler_pkg;

  localparam int REG_W   = 192;
  localparam int ERR_LEN = 0;
  localparam int ERR_TMO = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/concat_scheduler_if.sv
// Command handshake between host and concat scheduler.
// Host offers a register set plus expected beat count.
interface concat_scheduler_if #(
  parameter int BEAT_W = 24
);
  import concat_scheduler_pkg::*;

  logic              Cmd_Valid;
  logic              Cmd_Ready;
  logic [REG_W-1:0]  Cmd_Regs;
  logic [BEAT_W-1:0] Cmd_Beats;

  modport master (
    output Cmd_Valid,
    output Cmd_Regs,
    output Cmd_Beats,
    input  Cmd_Ready
  );

  modport slave (
    input  Cmd_Valid,
    input  Cmd_Regs,
    input  Cmd_Beats,
    output Cmd_Ready
  );

endinterface

// File: rtl/concat_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles, cleared on activity.
// Expires on the cycle the count would reach all-ones.
module concat_watchdog #(
  parameter int TMO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMO_W-1:0] MAX = '1;

  logic [TMO_W-1:0] cnt;

  assign expire = en && !clr &&
                  (cnt == MAX - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/concat_scheduler.sv
// Sequences one concat layer: latch regs, start, watch beats, finish.
// Flags beat/Last mismatches and stalled output streams.
module concat_scheduler
  import concat_scheduler_pkg::*;
#(
  parameter int BEAT_W = 24,
  parameter int TMO_W  = 20
) (
  input  logic               clk,
  input  logic               rst,
  concat_scheduler_if.slave  cmd,
  input  logic               M_Valid,
  input  logic               M_Ready,
  input  logic               Last_Concat,
  output logic [REG_W-1:0]   Reg_Bus,
  output logic               Start_Concat,
  output logic               Next_Reg,
  output logic               Busy,
  output logic               Done,
  output logic [1:0]         Err,
  output logic [BEAT_W-1:0]  Beat_Count
);

  state_t            state;
  logic [BEAT_W-1:0] exp_beats;
  logic              beat;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_expire;
  logic [BEAT_W:0]   cnt_nxt;
  logic [BEAT_W-1:0] cnt_sat;
  logic              over;
  logic              ready_q;

  assign beat    = M_Valid & M_Ready;
  assign cnt_nxt = {1'b0, Beat_Count} + 1'b1;
  assign cnt_sat = (&Beat_Count) ? Beat_Count
                 : Beat_Count + 1'b1;
  assign over    = cnt_nxt > {1'b0, exp_beats};
  assign wd_en   = (state == S_RUN);
  assign wd_clr  = (state != S_RUN) | beat;

  assign cmd.Cmd_Ready = ready_q;

  concat_watchdog #(
    .TMO_W (TMO_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      Reg_Bus      <= '0;
      exp_beats    <= '0;
      Beat_Count   <= '0;
      Err          <= '0;
      Start_Concat <= 1'b0;
      Next_Reg     <= 1'b0;
      Done         <= 1'b0;
      Busy         <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      Start_Concat <= 1'b0;
      Next_Reg     <= 1'b0;
      Done         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd.Cmd_Valid && ready_q) begin
            Reg_Bus    <= cmd.Cmd_Regs;
            exp_beats  <= cmd.Cmd_Beats;
            Beat_Count <= '0;
            Err        <= '0;
            Busy       <= 1'b1;
            ready_q    <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (exp_beats == '0)
            Err[ERR_LEN] <= 1'b1;
          Start_Concat <= 1'b1;
          state        <= S_START;
        end
        S_START: begin
          state <= S_RUN;
        end
        S_RUN: begin
          // A beat always wins over a same-cycle watchdog expiry.
          if (beat) begin
            Beat_Count <= cnt_sat;
            if (Last_Concat || over) begin
              if (cnt_nxt != {1'b0, exp_beats})
                Err[ERR_LEN] <= 1'b1;
              Next_Reg <= 1'b1;
              Done     <= 1'b1;
              state    <= S_DONE;
            end
          end else if (wd_expire) begin
            Err[ERR_TMO] <= 1'b1;
            Next_Reg     <= 1'b1;
            Done         <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          Busy    <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_concat_scheduler.sv
// Directed testbench for concat_scheduler.
// Watchdog shortened to TMO_W=4 so timeouts take 15 idle cycles.
module tb_concat_scheduler;
  import concat_scheduler_pkg::*;

  localparam int BW = 24;

  logic          clk;
  logic          rst;
  logic          M_Valid;
  logic          M_Ready;
  logic          Last_Concat;
  logic [191:0]  Reg_Bus;
  logic          Start_Concat;
  logic          Next_Reg;
  logic          Busy;
  logic          Done;
  logic [1:0]    Err;
  logic [BW-1:0] Beat_Count;

  int vecs;
  int errs;

  logic [191:0] ra;
  logic [191:0] rb;

  concat_scheduler_if #(.BEAT_W(BW)) cif ();

  concat_scheduler #(
    .BEAT_W (BW),
    .TMO_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cif),
    .M_Valid      (M_Valid),
    .M_Ready      (M_Ready),
    .Last_Concat  (Last_Concat),
    .Reg_Bus      (Reg_Bus),
    .Start_Concat (Start_Concat),
    .Next_Reg     (Next_Reg),
    .Busy         (Busy),
    .Done         (Done),
    .Err          (Err),
    .Beat_Count   (Beat_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic l);
    M_Valid     = v;
    M_Ready     = v;
    Last_Concat = l;
  endtask

  // Offer a command for one cycle; returns with DUT in LOAD.
  task automatic do_cmd(input logic [191:0] r, input logic [BW-1:0] b);
    cif.Cmd_Valid = 1'b1;
    cif.Cmd_Regs  = r;
    cif.Cmd_Beats = b;
    step();
    cif.Cmd_Valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    vecs++;
    if ({Busy, cif.Cmd_Ready, Start_Concat, Next_Reg, Done} !== 5'b01000) begin
      $display("FAIL reset_ctl got %b want 01000",
               {Busy, cif.Cmd_Ready, Start_Concat, Next_Reg, Done});
      errs++;
    end
    vecs++;
    if (Reg_Bus !== '0 || Beat_Count !== '0 || Err !== 2'b00) begin
      $display("FAIL reset_regs got bus=%h cnt=%0d err=%b want 0",
               Reg_Bus, Beat_Count, Err);
      errs++;
    end
    step();
    rst = 1'b1;
    step();
    vecs++;
    if ({Start_Concat, Next_Reg, Done, Busy} !== 4'b0000) begin
      $display("FAIL reset_release got %b want 0000",
               {Start_Concat, Next_Reg, Done, Busy});
      errs++;
    end
  endtask

  task automatic test_nominal();
    do_cmd(ra, 24'd16);
    vecs++;
    if (Reg_Bus !== ra || Busy !== 1'b1 || cif.Cmd_Ready !== 1'b0
        || Start_Concat !== 1'b0) begin
      $display("FAIL nom_load got bus=%h busy=%b rdy=%b st=%b",
               Reg_Bus, Busy, cif.Cmd_Ready, Start_Concat);
      errs++;
    end
    // Beats during LOAD/START must be ignored.
    set_beat(1'b1, 1'b1);
    step();
    vecs++;
    if (Start_Concat !== 1'b1) begin
      $display("FAIL nom_start got %b want 1", Start_Concat);
      errs++;
    end
    step();
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Start_Concat !== 1'b0 || Beat_Count !== '0 || Done !== 1'b0) begin
      $display("FAIL nom_run_entry got st=%b cnt=%0d done=%b want 0 0 0",
               Start_Concat, Beat_Count, Done);
      errs++;
    end
    for (int i = 1; i <= 16; i++) begin
      set_beat(1'b1, i == 16);
      step();
    end
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Done !== 1'b1 || Next_Reg !== 1'b1 || Err !== 2'b00
        || Beat_Count !== 24'd16) begin
      $display("FAIL nom_done got done=%b nr=%b err=%b cnt=%0d want 1 1 00 16",
               Done, Next_Reg, Err, Beat_Count);
      errs++;
    end
    step();
    vecs++;
    if (Done !== 1'b0 || Busy !== 1'b0 || cif.Cmd_Ready !== 1'b1
        || Beat_Count !== 24'd16) begin
      $display("FAIL nom_idle got done=%b busy=%b rdy=%b cnt=%0d",
               Done, Busy, cif.Cmd_Ready, Beat_Count);
      errs++;
    end
  endtask

  task automatic test_early_last();
    int dn;
    dn = 0;
    do_cmd(rb, 24'd16);
    step();
    step();
    for (int i = 1; i <= 10; i++) begin
      set_beat(1'b1, i == 10);
      step();
      if (Done) dn++;
    end
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Err !== 2'b01 || Beat_Count !== 24'd10) begin
      $display("FAIL early_last got err=%b cnt=%0d want 01 10",
               Err, Beat_Count);
      errs++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (Done) dn++;
    end
    vecs++;
    if (dn !== 1) begin
      $display("FAIL early_done_count got %0d want 1", dn);
      errs++;
    end
  endtask

  task automatic test_overrun();
    do_cmd(ra, 24'd4);
    step();
    step();
    for (int i = 1; i <= 5; i++) begin
      set_beat(1'b1, 1'b0);
      step();
    end
    vecs++;
    if (Err !== 2'b01 || Done !== 1'b1 || Beat_Count !== 24'd5) begin
      $display("FAIL overrun got err=%b done=%b cnt=%0d want 01 1 5",
               Err, Done, Beat_Count);
      errs++;
    end
    step();
    set_beat(1'b0, 1'b0);
    step();
    vecs++;
    if (Beat_Count !== 24'd5 || Busy !== 1'b0) begin
      $display("FAIL overrun_6th got cnt=%0d busy=%b want 5 0",
               Beat_Count, Busy);
      errs++;
    end
  endtask

  task automatic test_timeout();
    int n;
    do_cmd(rb, 24'd8);
    step();
    n = 0;
    while (!Done && n < 40) begin
      step();
      n++;
    end
    vecs++;
    if (n !== 16 || Err !== 2'b10) begin
      $display("FAIL timeout got cycles=%0d err=%b want 16 10", n, Err);
      errs++;
    end
    step();
  endtask

  task automatic test_tie();
    do_cmd(ra, 24'd1);
    step();
    step();
    for (int i = 1; i < 15; i++) step();
    set_beat(1'b1, 1'b1);
    step();
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Done !== 1'b1 || Err !== 2'b00 || Beat_Count !== 24'd1) begin
      $display("FAIL tie got done=%b err=%b cnt=%0d want 1 00 1",
               Done, Err, Beat_Count);
      errs++;
    end
    step();
  endtask

  task automatic test_zero_beats();
    do_cmd(rb, 24'd0);
    step();
    vecs++;
    if (Err !== 2'b01 || Start_Concat !== 1'b1) begin
      $display("FAIL zero_load got err=%b st=%b want 01 1",
               Err, Start_Concat);
      errs++;
    end
    step();
    set_beat(1'b1, 1'b0);
    step();
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Done !== 1'b1 || Beat_Count !== 24'd1 || Err !== 2'b01) begin
      $display("FAIL zero_run got done=%b cnt=%0d err=%b want 1 1 01",
               Done, Beat_Count, Err);
      errs++;
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int dn;
    dn = 0;
    do_cmd(ra, 24'd16);
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      set_beat(1'b1, 1'b0);
      step();
    end
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Beat_Count !== 24'd7) begin
      $display("FAIL mid_pre got cnt=%0d want 7", Beat_Count);
      errs++;
    end
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if (Busy !== 1'b0 || Beat_Count !== '0 || cif.Cmd_Ready !== 1'b1
        || Reg_Bus !== '0 || Err !== 2'b00) begin
      $display("FAIL mid_reset got busy=%b cnt=%0d rdy=%b err=%b",
               Busy, Beat_Count, cif.Cmd_Ready, Err);
      errs++;
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (Done || Next_Reg) dn++;
    end
    vecs++;
    if (dn !== 0) begin
      $display("FAIL mid_no_done got %0d pulses want 0", dn);
      errs++;
    end
    do_cmd(rb, 24'd2);
    vecs++;
    if (Busy !== 1'b1 || Reg_Bus !== rb) begin
      $display("FAIL mid_new_cmd got busy=%b bus=%h", Busy, Reg_Bus);
      errs++;
    end
    step();
    step();
    set_beat(1'b1, 1'b0);
    step();
    set_beat(1'b1, 1'b1);
    step();
    set_beat(1'b0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    cif.Cmd_Valid = 1'b1;
    cif.Cmd_Regs  = ra;
    cif.Cmd_Beats = 24'd2;
    step();
    cif.Cmd_Regs  = rb;
    cif.Cmd_Beats = 24'd3;
    step();
    step();
    set_beat(1'b1, 1'b0);
    step();
    set_beat(1'b1, 1'b1);
    step();
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Done !== 1'b1 || Reg_Bus !== ra || cif.Cmd_Ready !== 1'b0) begin
      $display("FAIL b2b_done got done=%b rdy=%b bus=%h",
               Done, cif.Cmd_Ready, Reg_Bus);
      errs++;
    end
    step();
    vecs++;
    if (Reg_Bus !== ra || cif.Cmd_Ready !== 1'b1 || Busy !== 1'b0) begin
      $display("FAIL b2b_idle got rdy=%b busy=%b bus=%h",
               cif.Cmd_Ready, Busy, Reg_Bus);
      errs++;
    end
    step();
    cif.Cmd_Valid = 1'b0;
    vecs++;
    if (Reg_Bus !== rb || Busy !== 1'b1 || Err !== 2'b00
        || Beat_Count !== '0) begin
      $display("FAIL b2b_accept got bus=%h busy=%b err=%b cnt=%0d",
               Reg_Bus, Busy, Err, Beat_Count);
      errs++;
    end
    step();
    step();
    for (int i = 1; i <= 3; i++) begin
      set_beat(1'b1, i == 3);
      step();
    end
    set_beat(1'b0, 1'b0);
    vecs++;
    if (Done !== 1'b1 || Err !== 2'b00 || Beat_Count !== 24'd3) begin
      $display("FAIL b2b_l2 got done=%b err=%b cnt=%0d want 1 00 3",
               Done, Err, Beat_Count);
      errs++;
    end
    step();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    ra = {6{32'hA5A5_0F0F}};
    rb = {6{32'h1234_C3C3}};
    cif.Cmd_Valid = 1'b0;
    cif.Cmd_Regs  = '0;
    cif.Cmd_Beats = '0;
    set_beat(1'b0, 1'b0);
    rst = 1'b1;
    #2;
    test_reset();
    test_nominal();
    test_early_last();
    test_overrun();
    test_timeout();
    test_tie();
    test_zero_beats();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/concat_scheduler.md
CONCAT_SCHEDULER -- requirements
Module: concat_scheduler

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-low.
REQ-002 Parameter BEAT_W, default 24: width of the expected output-beat count.
REQ-003 Parameter TMO_W, default 20: width of the watchdog counter; timeout fires at 2^TMO_W-1 idle cycles.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 Cmd_Valid  in  1  host offers one concat command.
REQ-007 Cmd_Ready  out  1  scheduler accepts the command; transfer occurs when Cmd_Valid&Cmd_Ready.
REQ-008 Cmd_Regs  in  192  {Reg_9,Reg_8,Reg_7,Reg_6,Reg_5,Reg_4} for the layer.
REQ-009 Cmd_Beats  in  BEAT_W  expected number of output beats for the layer; 0 is illegal.
REQ-010 Reg_Bus  out  192  latched copy of Cmd_Regs, driven to the concat datapath.
REQ-011 Start_Concat  out  1  one-cycle start pulse to the datapath.
REQ-012 Next_Reg  out  1  one-cycle pulse telling the datapath to release the current register set.
REQ-013 M_Valid, M_Ready  in  1 each  snooped output-stream handshake.
REQ-014 Last_Concat  in  1  datapath end-of-layer flag, qualified by M_Valid&M_Ready.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Done  out  1  one-cycle pulse at layer completion, with or without error.
REQ-017 Err  out  2  sticky: bit0 = beat/Last mismatch, bit1 = watchdog timeout.
REQ-018 Beat_Count  out  BEAT_W  beats observed in the current layer.

Function
REQ-019 FSM states: IDLE, LOAD, START, RUN, DONE. Encoding is free.
REQ-020 IDLE: Cmd_Ready=1. On the handshake, latch Cmd_Regs into Reg_Bus, latch Cmd_Beats, clear Beat_Count and Err, then go to LOAD.
REQ-021 LOAD: lasts exactly one cycle with Reg_Bus stable, then goes to START. The datapath latches its registers on the Start edge.
REQ-022 START: Start_Concat=1 for exactly one cycle, then go to RUN. Start_Concat occurs 2 cycles after the accepting edge.
REQ-023 RUN: each cycle with M_Valid&M_Ready increments Beat_Count, saturating at all-ones.
REQ-024 RUN: a beat with Last_Concat=1 goes to DONE. Err[0] is set if Beat_Count+1 != expected.
REQ-025 RUN: a beat taking Beat_Count past the expected value without Last_Concat sets Err[0] and goes to DONE.
REQ-026 RUN watchdog: counter cleared on every beat, incremented otherwise. At all-ones it sets Err[1] and goes to DONE.
REQ-027 DONE: Next_Reg=1 and Done=1 for exactly one cycle, then go to IDLE.
REQ-028 Cmd_Ready=0 outside IDLE. Back-to-back commands are accepted no earlier than the cycle after DONE.
REQ-029 Beats outside RUN are ignored and do not alter Beat_Count.
REQ-030 Cmd_Beats=0 sets Err[0] in LOAD. START is still issued, and RUN terminates on the first beat.
REQ-031 Simultaneous Last_Concat beat and watchdog expiry: the beat wins; no Err[1] is set.
REQ-032 Err and Beat_Count hold their value in IDLE until the next accepted command.

Reset
REQ-033 Assertion, asynchronous: FSM goes to IDLE. Reg_Bus, Beat_Count, Err, watchdog and expected count go to 0. Start_Concat, Next_Reg and Done go to 0. Busy=0, Cmd_Ready=1 after release.
REQ-034 Reset mid-RUN aborts the layer without emitting Done or Next_Reg. The datapath is reset by the same rst.
REQ-035 Deassertion is synchronised externally; no pulse output is asserted in the first cycle after release.

Structure
REQ-036 FSM state encoding, the 192-bit register-bus width and the Err bit indices live in the shared parameter include used by the TJPU blocks.
REQ-037 Single sub-module concat_watchdog (TMO_W counter with clear/enable/expire) is instantiated once. All other logic is flat.

Verification
REQ-038 Nominal: Cmd_Beats=16, Last_Concat on the 16th beat. Expected: Start_Concat 2 cycles after accept; Done and Next_Reg 1 cycle after the 16th beat; Err=0; Beat_Count=16.
REQ-039 Early Last: Cmd_Beats=16, Last_Concat on beat 10. Expected: Err=2'b01, Beat_Count=10, Done pulses once.
REQ-040 Overrun: Cmd_Beats=4, 5 beats without Last. Expected: Err=2'b01 at beat 5, Done; the 6th beat is ignored and Beat_Count stays 5.
REQ-041 Timeout with TMO_W=4: Start, then no beats. Expected: Err=2'b10 after 15 idle cycles in RUN, then Done.
REQ-042 Reset mid-RUN after 7 beats. Expected: immediate IDLE, Beat_Count=0, no Done/Next_Reg. A new command is accepted normally.
REQ-043 Back-to-back: second Cmd_Valid held high through layer 1. Expected: accepted the cycle after DONE; Reg_Bus changes only at that edge.
